// File: rtl/wb_ram_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone RAM arbiter: grant states double as the one-hot gnt vector.
// Also holds the bus widths and the request bundle used for output muxing.
package wb_ram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic              cyc;
    logic              stb;
  } wb_req_t;

  // Tie-break: round-robin hands the bus to whoever was not served last; fixed priority favours the data port.
  function automatic logic [1:0] tie_pick(input logic rr, input logic last);
    return (rr && last) ? GNT0 : GNT1;
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// Bundle of both master ports, the shared slave port and the grant vector.
// The arbiter uses the slave modport; the requesters and RAM model use the master modport.
interface wb_ram_arbiter_if;
  import wb_ram_arbiter_pkg::*;

  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [SEL_W-1:0]  m0_sel,   m1_sel;
  logic              m0_we,    m1_we;
  logic              m0_cyc,   m1_cyc;
  logic              m0_stb,   m1_stb;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_ack,   m1_ack;
  logic              m0_err,   m1_err;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [SEL_W-1:0]  s_sel;
  logic              s_we;
  logic              s_cyc;
  logic              s_stb;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ack;

  logic [1:0]        gnt;

  modport slave (
    input  m0_addr, m0_wdata, m0_sel, m0_we, m0_cyc, m0_stb,
    input  m1_addr, m1_wdata, m1_sel, m1_we, m1_cyc, m1_stb,
    output m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
    output s_addr, s_wdata, s_sel, s_we, s_cyc, s_stb, gnt,
    input  s_rdata, s_ack
  );

  modport master (
    output m0_addr, m0_wdata, m0_sel, m0_we, m0_cyc, m0_stb,
    output m1_addr, m1_wdata, m1_sel, m1_we, m1_cyc, m1_stb,
    input  m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
    input  s_addr, s_wdata, s_sel, s_we, s_cyc, s_stb, gnt,
    output s_rdata, s_ack
  );

endinterface

// File: rtl/wb_ram_arbiter_watchdog.sv
// Saturating count of unanswered strobe cycles; expired is high while the count sits at TIMEOUT.
// TIMEOUT=0 keeps the counter at zero so expired never fires.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic count_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (count_en && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master single-slave Wishbone classic arbiter: grant one cycle after request, held for the whole cyc.
// Losers wait with ack/err/rdata low; an unanswered strobe is cut off with a one-cycle err pulse.
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_ram_arbiter_if.slave        bus
);

  logic [1:0] state, state_nxt;
  logic       last;
  logic       expired;
  logic       rq0, rq1;
  logic       granted;
  wb_req_t    req0, req1, greq;

  assign req0 = '{addr: bus.m0_addr, wdata: bus.m0_wdata, sel: bus.m0_sel,
                  we: bus.m0_we, cyc: bus.m0_cyc, stb: bus.m0_stb};
  assign req1 = '{addr: bus.m1_addr, wdata: bus.m1_wdata, sel: bus.m1_sel,
                  we: bus.m1_we, cyc: bus.m1_cyc, stb: bus.m1_stb};

  assign rq0     = bus.m0_cyc & bus.m0_stb;
  assign rq1     = bus.m1_cyc & bus.m1_stb;
  assign granted = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rq0 && rq1)  state_nxt = tie_pick(ROUND_ROBIN, last);
        else if (rq1)    state_nxt = GNT1;
        else if (rq0)    state_nxt = GNT0;
      end
      GNT0:    if (expired || !bus.m0_cyc) state_nxt = IDLE;
      GNT1:    if (expired || !bus.m1_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT0)      last <= 1'b0;
      else if (state == IDLE && state_nxt == GNT1) last <= 1'b1;
    end
  end

  always_comb begin
    greq = '0;
    if (state == GNT0)      greq = req0;
    else if (state == GNT1) greq = req1;
  end

  // Any state change also clears the counter, so a timed-out master starts fresh on its next grant.
  wb_ack_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr      (!granted || bus.s_ack || !greq.stb || (state_nxt != state)),
    .count_en (granted && greq.stb && !bus.s_ack),
    .expired  (expired)
  );

  assign bus.s_addr  = greq.addr;
  assign bus.s_wdata = greq.wdata;
  assign bus.s_sel   = greq.sel;
  assign bus.s_we    = greq.we;
  assign bus.s_cyc   = greq.cyc & ~expired;
  assign bus.s_stb   = greq.stb & ~expired;
  assign bus.gnt     = state;

  assign bus.m0_ack   = (state == GNT0) & bus.s_ack & ~expired;
  assign bus.m1_ack   = (state == GNT1) & bus.s_ack & ~expired;
  assign bus.m0_err   = (state == GNT0) & expired;
  assign bus.m1_err   = (state == GNT1) & expired;
  assign bus.m0_rdata = (state == GNT0) ? bus.s_rdata : '0;
  assign bus.m1_rdata = (state == GNT1) ? bus.s_rdata : '0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench: a round-robin instance fronting a one-wait-state RAM model, and a fixed-priority
// instance fronting a slave that never acks. Reads are scoreboarded through a queue of expected data.
module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_ram_arbiter_if a ();
  wb_ram_arbiter_if b ();

  wb_ram_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(4)) u_rr (.clk(clk), .reset(reset), .bus(a));
  wb_ram_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(4)) u_fp (.clk(clk), .reset(reset), .bus(b));

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem [256];
  logic        a_seen = 1'b0;
  logic        a_en   = 1'b1;
  int          fp_grants, fp_errs;
  logic [1:0]  fp_prev;

  // RAM model: strobe seen in one cycle is acked in the next.
  always @(negedge clk) a_seen = a.s_cyc & a.s_stb & ~a.s_ack & a_en;

  initial begin
    a.s_ack   = 1'b0;
    a.s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      a.s_ack   = 1'b0;
      a.s_rdata = '0;
      if (reset && a_seen && a.s_cyc && a.s_stb) begin
        a.s_ack = 1'b1;
        if (a.s_we) begin
          for (int k = 0; k < 4; k++)
            if (a.s_sel[k]) mem[a.s_addr[9:2]][8*k +: 8] = a.s_wdata[8*k +: 8];
        end else begin
          a.s_rdata = mem[a.s_addr[9:2]];
        end
      end
    end
  end

  initial begin
    b.s_ack   = 1'b0;
    b.s_rdata = '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_run++;
      n_fail++;
      $error("FAIL %s: observed %h expected nothing (scoreboard empty)", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    a.m0_cyc = cyc; a.m0_stb = stb; a.m0_we = we;
    a.m0_addr = addr; a.m0_wdata = wdata; a.m0_sel = sel;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    a.m1_cyc = cyc; a.m1_stb = stb; a.m1_we = we;
    a.m1_addr = addr; a.m1_wdata = wdata; a.m1_sel = sel;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = 32'hDEADBEEF;
    mem[65] = 32'hCAFEF00D;
    m0_set(0, 0, 0, '0, '0, '0);
    m1_set(0, 0, 0, '0, '0, '0);
    b.m0_cyc = 0; b.m0_stb = 0; b.m0_we = 0; b.m0_addr = '0; b.m0_wdata = '0; b.m0_sel = '0;
    b.m1_cyc = 0; b.m1_stb = 0; b.m1_we = 0; b.m1_addr = '0; b.m1_wdata = '0; b.m1_sel = '0;

    // Reset state, then the first idle cycle after release.
    repeat (2) smp();
    chk("rst_gnt", a.gnt, 0);
    chk("rst_s_cyc", a.s_cyc, 0);
    chk("rst_s_addr", a.s_addr, 0);
    chk("rst_m0_ack", a.m0_ack, 0);
    step(); reset = 1'b1;
    smp();
    chk("rel_gnt", a.gnt, 0);
    chk("rel_s_stb", a.s_stb, 0);
    chk("rel_m1_err", a.m1_err, 0);

    // Fixed priority with both masters hammering a silent slave: m1 always wins.
    step();
    b.m0_cyc = 1; b.m0_stb = 1; b.m1_cyc = 1; b.m1_stb = 1;
    smp(); chk("fp_c0_idle", b.gnt, 0);
    smp(); chk("fp_first_gnt", b.gnt, 2'b10);
    fp_grants = 1; fp_errs = 0; fp_prev = b.gnt;
    for (int i = 0; i < 30; i++) begin
      smp();
      chk("fp_no_m0_gnt", (b.gnt == 2'b01), 0);
      chk("fp_m0_ack", b.m0_ack, 0);
      if (fp_prev == 2'b00 && b.gnt == 2'b10) fp_grants++;
      if (b.m1_err) fp_errs++;
      fp_prev = b.gnt;
    end
    chk("fp_grant_count", fp_grants, 6);
    chk("fp_err_count", fp_errs, 5);
    step();
    b.m0_cyc = 0; b.m0_stb = 0; b.m1_cyc = 0; b.m1_stb = 0;

    // Single m0 read.
    step(); m0_set(1, 1, 0, 32'h100, '0, 4'hF); exp_q.push_back(32'hDEADBEEF);
    smp(); chk("t1_idle", a.gnt, 0);
    smp(); chk("t1_gnt", a.gnt, 2'b01); chk("t1_s_stb", a.s_stb, 1);
           chk("t1_s_addr", a.s_addr, 32'h100); chk("t1_ack_early", a.m0_ack, 0);
    smp(); chk("t1_m0_ack", a.m0_ack, 1); pop_chk("t1_m0_rdata", a.m0_rdata);
           chk("t1_m1_ack", a.m1_ack, 0); chk("t1_m1_rdata", a.m1_rdata, 0);
    step(); m0_set(0, 0, 0, '0, '0, '0);
    step();

    // Round-robin ties: m1, one idle gap, m0, then m1 again.
    m0_set(1, 1, 0, 32'h100, '0, 4'hF);
    m1_set(1, 1, 0, 32'h104, '0, 4'hF);
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hDEADBEEF);
    smp();
    smp(); chk("t2_tie_m1", a.gnt, 2'b10);
    smp(); chk("t2_m1_ack", a.m1_ack, 1); pop_chk("t2_m1_rdata", a.m1_rdata);
           chk("t2_m0_wait_ack", a.m0_ack, 0); chk("t2_m0_wait_rdata", a.m0_rdata, 0);
    step(); m1_set(0, 0, 0, '0, '0, '0);
    smp(); chk("t2_hold", a.gnt, 2'b10);
    smp(); chk("t2_gap", a.gnt, 2'b00);
    smp(); chk("t2_m0_gnt", a.gnt, 2'b01);
    smp(); chk("t2_m0_ack", a.m0_ack, 1); pop_chk("t2_m0_rdata", a.m0_rdata);
    step(); m0_set(0, 0, 0, '0, '0, '0);
    step();
    m0_set(1, 1, 0, 32'h100, '0, 4'hF);
    m1_set(1, 1, 0, 32'h104, '0, 4'hF);
    exp_q.push_back(32'hCAFEF00D);
    smp();
    smp(); chk("t2_tie2_m1", a.gnt, 2'b10);
    smp(); chk("t2_tie2_ack", a.m1_ack, 1); pop_chk("t2_tie2_rdata", a.m1_rdata);
    step(); m0_set(0, 0, 0, '0, '0, '0); m1_set(0, 0, 0, '0, '0, '0);
    step();

    // Locked two-beat m1 write while m0 requests mid-cycle.
    m1_set(1, 1, 1, 32'h40, 32'h12345678, 4'b0011);
    smp();
    smp(); chk("t3_gnt", a.gnt, 2'b10); chk("t3_s_we", a.s_we, 1);
           chk("t3_s_wdata", a.s_wdata, 32'h12345678); chk("t3_s_sel", a.s_sel, 4'b0011);
    step(); m0_set(1, 1, 0, 32'h100, '0, 4'hF); exp_q.push_back(32'hDEADBEEF);
    smp(); chk("t3_m1_ack", a.m1_ack, 1); chk("t3_m0_wait", a.m0_ack, 0);
           chk("t3_wdata_hold", a.s_wdata, 32'h12345678);
    step(); a.m1_stb = 1'b0;
    smp(); chk("t3_lock", a.gnt, 2'b10); chk("t3_gap_stb", a.s_stb, 0); chk("t3_m0_wait2", a.m0_ack, 0);
    step(); a.m1_stb = 1'b1;
    smp(); chk("t3_beat2_sel", a.s_sel, 4'b0011); chk("t3_beat2_wdata", a.s_wdata, 32'h12345678);
    smp(); chk("t3_beat2_ack", a.m1_ack, 1); chk("t3_m0_wait3", a.m0_ack, 0);
    step(); m1_set(0, 0, 0, '0, '0, '0);
    smp(); chk("t3_release_hold", a.gnt, 2'b10);
    smp(); chk("t3_gap", a.gnt, 2'b00);
    smp(); chk("t3_m0_gnt", a.gnt, 2'b01);
    smp(); chk("t3_m0_ack", a.m0_ack, 1); pop_chk("t3_m0_rdata", a.m0_rdata);
    chk("t3_mem_masked", mem[16], 32'h00005678);
    step(); m0_set(0, 0, 0, '0, '0, '0);
    step();

    // Watchdog: silent slave, err on the fifth strobe cycle.
    a_en = 1'b0;
    m0_set(1, 1, 0, 32'h100, '0, 4'hF);
    smp();
    for (int i = 1; i <= 4; i++) begin
      smp();
      chk("t4_no_err", a.m0_err, 0);
      chk("t4_stb", a.s_stb, 1);
    end
    smp(); chk("t4_err", a.m0_err, 1); chk("t4_stb_cut", a.s_stb, 0);
           chk("t4_cyc_cut", a.s_cyc, 0); chk("t4_no_ack", a.m0_ack, 0);
    smp(); chk("t4_idle_after", a.gnt, 0); chk("t4_err_pulse", a.m0_err, 0);
    smp(); chk("t4_rearb", a.gnt, 2'b01);
    step(); m0_set(0, 0, 0, '0, '0, '0); a_en = 1'b1;
    step();

    // Asynchronous reset during a GNT1 transfer, then a tie after release.
    m1_set(1, 1, 0, 32'h104, '0, 4'hF); exp_q.push_back(32'hCAFEF00D);
    smp();
    smp(); chk("t5_gnt", a.gnt, 2'b10);
    smp(); chk("t5_ack_pre", a.m1_ack, 1); pop_chk("t5_rdata_pre", a.m1_rdata);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_cyc", a.s_cyc, 0);
    chk("t5_rst_stb", a.s_stb, 0);
    chk("t5_rst_gnt", a.gnt, 0);
    chk("t5_rst_m1_ack", a.m1_ack, 0);
    m0_set(1, 1, 0, 32'h100, '0, 4'hF);
    step(); step();
    reset = 1'b1;
    smp(); chk("t5_rel_gnt", a.gnt, 0); chk("t5_rel_s_cyc", a.s_cyc, 0);
           chk("t5_rel_m1_ack", a.m1_ack, 0); chk("t5_rel_m0_rdata", a.m0_rdata, 0);
    smp(); chk("t5_tie_m1", a.gnt, 2'b10);
    step(); m0_set(0, 0, 0, '0, '0, '0); m1_set(0, 0, 0, '0, '0, '0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master, one-slave Wishbone (classic, single-beat) arbiter in front of the shared SoC RAM.
- Master 0 is the instruction port; master 1 is the data port.
- Grants the slave to one master for the whole bus cycle (held while that master's cyc is high).
- Routes ack/rdata only to the granted master and enforces an ack timeout that returns err instead of hanging the core.

Parameters:
- ROUND_ROBIN, 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, master 1 (data) wins.
- TIMEOUT, 255: cycles of unanswered strobe before err; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1) (min 1): watchdog counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_addr / m1_addr  in  32  master byte address.
- m0_wdata / m1_wdata  in  32  master write data.
- m0_sel / m1_sel  in  4  byte lane selects.
- m0_we / m1_we  in  1  write enable.
- m0_cyc / m1_cyc  in  1  bus cycle request.
- m0_stb / m1_stb  in  1  strobe.
- m0_rdata / m1_rdata  out  32  read data; s_rdata when granted, else 0.
- m0_ack / m1_ack  out  1  s_ack gated by grant.
- m0_err / m1_err  out  1  one-cycle timeout error pulse.
- s_addr, s_wdata, s_sel, s_we  out  32,32,4,1  granted master's signals; 0 when idle.
- s_cyc, s_stb  out  1  granted master's cyc/stb; 0 when idle or in an err cycle.
- s_rdata  in  32  slave read data.
- s_ack  in  1  slave acknowledge.
- gnt  out  2  one-hot current grant {m1,m0}; 00 when idle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=00, last=0 (m0 last served), wdog=0.
  - All s_* and m*_ack/err/rdata outputs are 0 while reset is asserted and in the first idle cycle after release.
  - Reset mid-transfer drops s_cyc immediately. The in-flight slave transaction is abandoned; no ack is forwarded.
- States: IDLE, GNT0, GNT1 (registered). Output muxing is combinational from the state.
- IDLE: a request is mX_cyc & mX_stb.
  - One requester: go to GNTX.
  - Both requesting, ROUND_ROBIN=1: grant the master not equal to last. After reset, m1 wins the first tie.
  - Both requesting, ROUND_ROBIN=0: GNT1.
  - No request: stay IDLE.
- Arbitration latency: request sampled at edge E. s_cyc/s_stb are driven during the cycle after E. With a one-cycle-ack slave, mX_ack is seen 2 cycles after the request.
- GNTX:
  - s_* = mX_*. mX_ack = s_ack, mX_rdata = s_rdata.
  - The other master sees ack=0, err=0, rdata=0 and simply waits.
  - last <= X on entry.
- Release: at the edge where the granted mX_cyc=0, go to IDLE. Re-arbitration takes one idle cycle, so there is no back-to-back grant switch without a gap.
- Multi-beat cycles: cyc held with stb toggling keeps the grant. A master may issue several strobes under one cyc (lock).
- Watchdog (TIMEOUT>0):
  - wdog increments each GNTX cycle with s_stb=1 and s_ack=0, saturating at TIMEOUT.
  - wdog clears on s_ack, on any state change, and when stb=0.
  - When wdog==TIMEOUT:
    - mX_err=1 for that cycle.
    - s_cyc=s_stb=0 that cycle.
    - Next state is IDLE regardless of mX_cyc; wdog clears.
  - A master still holding cyc after err re-arbitrates as a new request.
- Simultaneous s_ack and wdog==TIMEOUT-1: the ack wins and the counter clears; no err.
- Slave asserting s_ack while IDLE: ignored, not forwarded.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10, matching gnt one-hot);
  - the Wishbone width constants (ADDR_W=32, DATA_W=32, SEL_W=4).
- The watchdog counter is a natural sub-module: wb_ack_watchdog (inputs clk, reset, clr, count_en; output expired).
- Grant FSM and muxing stay in the top.

Test Plan:
- Single m0 read of addr 0x100 holding 0xDEADBEEF, slave acks 1 cycle after strobe -> gnt=01 one cycle after request; m0_ack with m0_rdata=0xDEADBEEF 2 cycles after request; m1_ack stays 0.
- Both request on the same edge after reset, ROUND_ROBIN=1 -> m1 granted first. m1 drops cyc; 1 idle cycle; then m0 granted. Next tie -> m1 again.
- ROUND_ROBIN=0, m0 and m1 request continuously -> m1 granted on every arbitration and m0 starved; check gnt never 01 while m1_cyc is held.
- m1 write 0x12345678 sel=4'b0011 to 0x40 while m0 requests mid-cycle -> m0 waits with ack=0 until m1 releases; slave sees m1's wdata/sel unchanged through the cycle.
- TIMEOUT=4, slave never acks m0 -> m0_err=1 exactly on the 5th strobe cycle, s_stb=0 that cycle, state IDLE next edge, no m0_ack.
- reset pulled low during GNT1 with stb high -> s_cyc, gnt and m1_ack go 0 asynchronously; after release, first tie goes to m1.
